// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the async instruction ROM and
// fills the IF/ID register, handling stall/flush/redirect/halt and fetch faults.
//
// state | meaning
// BOOT  | first cycle after reset release; PC parked at RESET_VECTOR, IF/ID bubble
// RUN   | normal fetch with stall/flush/redirect handling
// HALT  | absorbing; PC and IF/ID frozen, valid low, left only through reset
module fetch_stage #(
  parameter int unsigned       DATA_W       = 32,
  parameter logic [DATA_W-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned       ROM_WORDS    = 256,
  parameter logic [DATA_W-1:0] NOP_WORD     = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] instr_in,
  input  logic              stall,
  input  logic              flush,
  input  logic              branch_taken,
  input  logic [DATA_W-1:0] branch_target,
  input  logic              jump,
  input  logic [DATA_W-1:0] jump_target,
  input  logic              halt_req,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [DATA_W-1:0] if_id_pc4,
  output logic              if_id_valid,
  output logic              fault,
  output logic              halted
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // One bit wider than the PC so the limit itself is representable.
  localparam logic [DATA_W:0] PC_LIMIT = (DATA_W+1)'(ROM_WORDS * 4);

  state_t            state;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] pc_plus4;
  logic [DATA_W-1:0] redirect_target;
  logic              redirect;
  logic              misaligned;
  logic              out_of_range;
  logic              fault_event;

  assign pc_out   = pc;
  assign pc_plus4 = pc + DATA_W'(4);

  // The branch is the older instruction, so its target wins over a jump.
  always_comb begin
    redirect        = branch_taken | jump;
    redirect_target = branch_taken ? branch_target : jump_target;
    misaligned      = redirect && (redirect_target[1:0] != 2'b00);
    out_of_range    = ({1'b0, pc} >= PC_LIMIT);
    fault_event     = misaligned | out_of_range;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      pc          <= RESET_VECTOR;
      if_id_instr <= NOP_WORD;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      fault       <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          state       <= ST_RUN;
          if_id_instr <= NOP_WORD;
          if_id_valid <= 1'b0;
        end
        ST_RUN: begin
          if (halt_req || fault_event) begin
            state       <= ST_HALT;
            halted      <= 1'b1;
            if_id_valid <= 1'b0;
            if (fault_event) fault <= 1'b1;
            // A word fetched from beyond the ROM is never exposed downstream.
            if (out_of_range) if_id_instr <= NOP_WORD;
          end else if (redirect) begin
            pc          <= redirect_target;
            if_id_instr <= NOP_WORD;
            if_id_valid <= 1'b0;
          end else if (flush) begin
            if_id_instr <= NOP_WORD;
            if_id_valid <= 1'b0;
            if (!stall) pc <= pc_plus4;
          end else if (!stall) begin
            pc          <= pc_plus4;
            if_id_instr <= instr_in;
            if_id_pc4   <= pc_plus4;
            if_id_valid <= 1'b1;
          end
        end
        ST_HALT: begin
          halted      <= 1'b1;
          if_id_valid <= 1'b0;
        end
        default: begin
          state       <= ST_HALT;
          halted      <= 1'b1;
          if_id_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table for the main fetch flow plus
// hand-written sequences for faults, halt and asynchronous reset.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_in;
  logic        stall = 0, flush = 0, branch_taken = 0, jump = 0, halt_req = 0;
  logic [31:0] branch_target = '0, jump_target = '0;
  logic [31:0] pc_out, if_id_instr, if_id_pc4;
  logic        if_id_valid, fault, halted;

  int tests = 0;
  int fails = 0;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target), .jump(jump),
    .jump_target(jump_target), .halt_req(halt_req), .pc_out(pc_out),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .fault(fault), .halted(halted)
  );

  always #5 clk = ~clk;

  // ROM contents: word i = 0x20080001 + i*0x00010001 (0x20080001, 0x20090002, ...)
  assign instr_in = (pc_out < 32'h400) ? (32'h2008_0001 + (pc_out >> 2) * 32'h0001_0001)
                                       : 32'hDEAD_BEEF;

  typedef struct {
    logic        st, fl, br;
    logic [31:0] br_t;
    logic        jp;
    logic [31:0] jp_t;
    logic        hr;
    logic [31:0] e_pc, e_instr, e_pc4;
    logic        e_valid, e_fault, e_halted;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                         input logic [31:0] e_pc4, input logic e_valid, input logic e_fault,
                         input logic e_halted);
    chk({tag, " pc"}, pc_out, e_pc);
    chk({tag, " instr"}, if_id_instr, e_instr);
    chk({tag, " pc4"}, if_id_pc4, e_pc4);
    chk({tag, " valid"}, {31'b0, if_id_valid}, {31'b0, e_valid});
    chk({tag, " fault"}, {31'b0, fault}, {31'b0, e_fault});
    chk({tag, " halted"}, {31'b0, halted}, {31'b0, e_halted});
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; branch_taken = 0; jump = 0; halt_req = 0;
    branch_target = '0; jump_target = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, check reset values, release, then check the BOOT edge.
  task automatic do_reset(input string tag);
    idle_inputs();
    rst_n = 0;
    step();
    chk_all({tag, " rst"}, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    rst_n = 1;
    step();
    chk_all({tag, " boot"}, 32'h0, 32'h0, 32'h0, 0, 0, 0);
  endtask

  initial begin
    //          st fl br br_t        jp jp_t        hr e_pc         e_instr       e_pc4     v  f  h
    vecs[0]  = '{0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h4,     32'h20080001, 32'h4,   1, 0, 0};
    vecs[1]  = '{0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h8,     32'h20090002, 32'h8,   1, 0, 0};
    vecs[2]  = '{1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h8,     32'h20090002, 32'h8,   1, 0, 0};
    vecs[3]  = '{1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h8,     32'h20090002, 32'h8,   1, 0, 0};
    vecs[4]  = '{0, 0, 0, 32'h0,     0, 32'h0,     0, 32'hC,     32'h200A0003, 32'hC,   1, 0, 0};
    vecs[5]  = '{0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h10,    32'h200B0004, 32'h10,  1, 0, 0};
    vecs[6]  = '{0, 0, 1, 32'h40,    1, 32'h80,    0, 32'h40,    32'h0,        32'h10,  0, 0, 0};
    vecs[7]  = '{0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h44,    32'h20180011, 32'h44,  1, 0, 0};
    vecs[8]  = '{0, 1, 0, 32'h0,     0, 32'h0,     0, 32'h48,    32'h0,        32'h44,  0, 0, 0};
    vecs[9]  = '{0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h4C,    32'h201A0013, 32'h4C,  1, 0, 0};
    vecs[10] = '{1, 1, 0, 32'h0,     0, 32'h0,     0, 32'h4C,    32'h0,        32'h4C,  0, 0, 0};
    vecs[11] = '{0, 0, 0, 32'h0,     1, 32'h100,   0, 32'h100,   32'h0,        32'h4C,  0, 0, 0};
    vecs[12] = '{1, 0, 0, 32'h0,     1, 32'h200,   0, 32'h200,   32'h0,        32'h4C,  0, 0, 0};
    vecs[13] = '{0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h204,   32'h20880081, 32'h204, 1, 0, 0};
    vecs[14] = '{0, 0, 1, 32'h3F8,   0, 32'h0,     0, 32'h3F8,   32'h0,        32'h204, 0, 0, 0};
    vecs[15] = '{0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h3FC,   32'h210600FF, 32'h3FC, 1, 0, 0};
    vecs[16] = '{0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h400,   32'h21070100, 32'h400, 1, 0, 0};
    vecs[17] = '{0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h400,   32'h0,        32'h400, 0, 1, 1};
    vecs[18] = '{0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h400,   32'h0,        32'h400, 0, 1, 1};
    vecs[19] = '{0, 0, 1, 32'h10,    0, 32'h0,     0, 32'h400,   32'h0,        32'h400, 0, 1, 1};

    #2;
    do_reset("main");
    for (int i = 0; i < 20; i++) begin
      stall = vecs[i].st; flush = vecs[i].fl;
      branch_taken = vecs[i].br; branch_target = vecs[i].br_t;
      jump = vecs[i].jp; jump_target = vecs[i].jp_t; halt_req = vecs[i].hr;
      step();
      chk_all($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pc4,
              vecs[i].e_valid, vecs[i].e_fault, vecs[i].e_halted);
    end

    // Misaligned jump target: PC not loaded, sticky fault and HALT.
    do_reset("mjump");
    idle_inputs(); step(); step();
    chk_all("mjump run", 32'h8, 32'h20090002, 32'h8, 1, 0, 0);
    jump = 1; jump_target = 32'h42;
    step();
    chk_all("mjump hit", 32'h8, 32'h20090002, 32'h8, 0, 1, 1);
    idle_inputs();
    for (int i = 0; i < 3; i++) step();
    chk_all("mjump hold", 32'h8, 32'h20090002, 32'h8, 0, 1, 1);

    // Misaligned branch wins over an aligned jump in the same cycle.
    do_reset("mbr");
    step();
    branch_taken = 1; branch_target = 32'h41; jump = 1; jump_target = 32'h80;
    step();
    chk_all("mbr hit", 32'h4, 32'h20080001, 32'h4, 0, 1, 1);

    // halt_req beats a branch; no fault raised.
    do_reset("halt");
    step();
    halt_req = 1; branch_taken = 1; branch_target = 32'h40;
    step();
    chk_all("halt hit", 32'h4, 32'h20080001, 32'h4, 0, 0, 1);
    idle_inputs(); step(); step();
    chk_all("halt hold", 32'h4, 32'h20080001, 32'h4, 0, 0, 1);

    // Asynchronous reset mid-cycle while stalled.
    do_reset("arst");
    step(); step();
    stall = 1;
    step();
    chk_all("arst stall", 32'h8, 32'h20090002, 32'h8, 1, 0, 0);
    #2;
    rst_n = 0;
    #1;
    chk_all("arst async", 32'h0, 32'h0, 32'h0, 0, 0, 0);
    idle_inputs();
    step();
    rst_n = 1;
    step();
    chk_all("arst boot", 32'h0, 32'h0, 32'h0, 0, 0, 0);
    step();
    chk_all("arst run", 32'h4, 32'h20080001, 32'h4, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
